// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, producer state encoding and the data word pattern
package fifo_pkg;
    localparam int DEPTH     = 512;
    localparam int WIDTH     = 1024;
    localparam int PTR_WIDTH = 9;

    typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} prod_state_e;

    function automatic logic [WIDTH-1:0] pattern(input logic [31:0] s);
        return {WIDTH/32{s}};
    endfunction
endpackage

// File: rtl/producer.sv
// producer: write-side burst traffic source for the async FIFO (clk1 domain)
// Ports: clk1/rst (async active-high), start/burst_len/gap_cycles request a burst,
// Full backpressure from the control unit, Write/Data_in to the FIFO write port,
// Busy during a burst, Done one-cycle completion pulse, seq next sequence number.
module producer
    import fifo_pkg::*;
(
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PTR_WIDTH:0]   burst_len,
    input  logic [3:0]           gap_cycles,
    input  logic                 Full,
    output logic                 Write,
    output logic [WIDTH-1:0]     Data_in,
    output logic                 Busy,
    output logic                 Done,
    output logic [31:0]          seq
);
    prod_state_e          state;
    logic [PTR_WIDTH:0]   remaining;
    logic [3:0]           gap;
    logic [3:0]           gap_cnt;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            gap       <= '0;
            gap_cnt   <= '0;
            seq       <= '0;
            Write     <= 1'b0;
            Data_in   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && burst_len == '0) begin
                        Done <= 1'b1;
                    end else if (start) begin
                        state     <= WRITE;
                        remaining <= burst_len;
                        gap       <= gap_cycles;
                        Write     <= 1'b1;
                        Busy      <= 1'b1;
                        Data_in   <= pattern(seq);
                    end
                end
                WRITE: begin
                    // while Full is high nothing changes, so Write/Data_in hold
                    if (!Full) begin
                        seq       <= seq + 32'd1;
                        remaining <= remaining - (PTR_WIDTH+1)'(1);
                        if (remaining == (PTR_WIDTH+1)'(1)) begin
                            state <= DONE;
                            Write <= 1'b0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else if (gap != 4'd0) begin
                            state   <= GAP;
                            gap_cnt <= gap;
                            Write   <= 1'b0;
                        end else begin
                            Data_in <= pattern(seq + 32'd1);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state   <= WRITE;
                        Write   <= 1'b1;
                        Data_in <= pattern(seq);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_producer.sv
// tb_producer: scoreboard bench for the producer burst source
module tb_producer;
    import fifo_pkg::*;

    logic                 clk1 = 1'b0;
    logic                 rst;
    logic                 start;
    logic [PTR_WIDTH:0]   burst_len;
    logic [3:0]           gap_cycles;
    logic                 Full;
    logic                 Write;
    logic [WIDTH-1:0]     Data_in;
    logic                 Busy;
    logic                 Done;
    logic [31:0]          seq;

    producer dut (
        .clk1(clk1), .rst(rst), .start(start), .burst_len(burst_len),
        .gap_cycles(gap_cycles), .Full(Full), .Write(Write), .Data_in(Data_in),
        .Busy(Busy), .Done(Done), .seq(seq)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_edge = 0;
    logic [31:0] m_seq = 0;
    logic [31:0] exp_q[$];
    int acc_q[$];

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string n, input logic ok, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic chk_data(input string n, input logic [31:0] s);
        logic [WIDTH-1:0] pv;
        logic [WIDTH-1:0] av;
        pv = pattern(s);
        av = Data_in;
        chk(n, av == pv, av[63:0], pv[63:0]);
    endtask

    always @(negedge clk1) begin
        if (!rst) begin
            if (Write && !Full) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1'b0, 64'(seq), 64'(seq));
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk_data("word_data", e);
                    chk("word_seq", seq == e, 64'(seq), 64'(e));
                end
                acc_q.push_back(cyc + 1);
                wr_cnt++;
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step;
        @(posedge clk1);
        #1;
    endtask

    task automatic go(input int len, input int g);
        start      = 1'b1;
        burst_len  = (PTR_WIDTH+1)'(len);
        gap_cycles = 4'(g);
        start_edge = cyc + 1;
        acc_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(m_seq);
            m_seq = m_seq + 32'd1;
        end
        step;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d;
        int n;
        d = done_cnt;
        n = 0;
        while (done_cnt == d && n < budget) begin
            step;
            n++;
        end
        chk("done_seen", done_cnt == d + 1, 64'(done_cnt - d), 64'd1);
    endtask

    initial begin
        int w0;
        int d0;
        int n;
        rst = 1'b1;
        start = 1'b0;
        burst_len = '0;
        gap_cycles = '0;
        Full = 1'b0;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        chk("rst_write", Write == 1'b0, 64'(Write), 64'd0);
        chk("rst_data", Data_in == '0, Data_in[63:0], 64'd0);
        chk("rst_busy", Busy == 1'b0, 64'(Busy), 64'd0);
        chk("rst_done", Done == 1'b0, 64'(Done), 64'd0);
        chk("rst_seq", seq == 32'd0, 64'(seq), 64'd0);
        step;

        go(4, 0);
        wait_done(20);
        chk("basic_accepts", acc_q.size() == 4, 64'(acc_q.size()), 64'd4);
        if (acc_q.size() == 4) begin
            chk("basic_first", acc_q[0] - start_edge == 1, 64'(acc_q[0] - start_edge), 64'd1);
            chk("basic_back2back", acc_q[3] - acc_q[0] == 3, 64'(acc_q[3] - acc_q[0]), 64'd3);
            chk("basic_done_time", done_cyc == acc_q[3], 64'(done_cyc), 64'(acc_q[3]));
        end
        chk("basic_seq", seq == 32'd4, 64'(seq), 64'd4);

        go(3, 0);
        step;
        Full = 1'b1;
        repeat (5) begin
            @(negedge clk1);
            chk("bp_write_hold", Write == 1'b1, 64'(Write), 64'd1);
            chk_data("bp_data_hold", 32'd5);
            step;
        end
        Full = 1'b0;
        wait_done(20);
        chk("bp_accepts", acc_q.size() == 3, 64'(acc_q.size()), 64'd3);
        if (acc_q.size() == 3)
            chk("bp_stall", acc_q[1] - acc_q[0] == 6, 64'(acc_q[1] - acc_q[0]), 64'd6);
        chk("bp_seq", seq == 32'd7, 64'(seq), 64'd7);

        go(2, 3);
        wait_done(30);
        chk("gap_accepts", acc_q.size() == 2, 64'(acc_q.size()), 64'd2);
        if (acc_q.size() == 2) begin
            chk("gap_first", acc_q[0] - start_edge == 1, 64'(acc_q[0] - start_edge), 64'd1);
            chk("gap_second", acc_q[1] - start_edge == 5, 64'(acc_q[1] - start_edge), 64'd5);
        end
        chk("gap_done_time", done_cyc - start_edge == 5, 64'(done_cyc - start_edge), 64'd5);

        w0 = wr_cnt;
        d0 = done_cnt;
        go(0, 0);
        @(negedge clk1);
        chk("zero_done", Done == 1'b1, 64'(Done), 64'd1);
        chk("zero_write", Write == 1'b0, 64'(Write), 64'd0);
        chk("zero_busy", Busy == 1'b0, 64'(Busy), 64'd0);
        step;
        @(negedge clk1);
        chk("zero_done_pulse", Done == 1'b0, 64'(Done), 64'd0);
        chk("zero_done_cnt", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);
        step;

        go(3, 1);
        step;
        start = 1'b1;
        burst_len = (PTR_WIDTH+1)'(5);
        step;
        start = 1'b0;
        wait_done(30);
        repeat (5) step;
        chk("ignored_start_writes", wr_cnt - w0 == 3, 64'(wr_cnt - w0), 64'd3);
        chk("ignored_start_busy", Busy == 1'b0, 64'(Busy), 64'd0);
        chk("ignored_start_seq", seq == 32'd12, 64'(seq), 64'd12);

        d0 = done_cnt;
        go(10, 0);
        n = 0;
        while (acc_q.size() < 3 && n < 30) begin
            step;
            n++;
        end
        chk("rst_mid_accepts", acc_q.size() == 3, 64'(acc_q.size()), 64'd3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        m_seq = 32'd0;
        #1;
        chk("rst_mid_write", Write == 1'b0, 64'(Write), 64'd0);
        chk("rst_mid_busy", Busy == 1'b0, 64'(Busy), 64'd0);
        chk("rst_mid_data", Data_in == '0, Data_in[63:0], 64'd0);
        chk("rst_mid_seq", seq == 32'd0, 64'(seq), 64'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        repeat (4) step;
        chk("rst_mid_no_done", done_cnt == d0, 64'(done_cnt), 64'(d0));
        go(2, 0);
        wait_done(20);
        chk("resume_seq", seq == 32'd2, 64'(seq), 64'd2);

        force dut.seq = 32'hFFFFFFFE;
        step;
        release dut.seq;
        step;
        chk("preload_seq", seq == 32'hFFFFFFFE, 64'(seq), 64'hFFFFFFFE);
        m_seq = 32'hFFFFFFFE;
        go(4, 0);
        wait_done(20);
        chk("wrap_seq", seq == 32'd2, 64'(seq), 64'd2);

        w0 = wr_cnt;
        go(512, 0);
        wait_done(600);
        chk("depth_writes", wr_cnt - w0 == 512, 64'(wr_cnt - w0), 64'd512);
        chk("depth_seq", seq == 32'd514, 64'(seq), 64'd514);
        chk("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/producer.md
# producer

Write-side traffic source for the asynchronous FIFO. It runs in the write clock domain (`clk1`) and issues bursts of self-checking data words into the FIFO write port. It drives `Write` and `Data_in` and obeys the `Full` flag from the control unit. It is the mirror of the consumer on the `clk2` read side. The data pattern is deterministic, so the consumer can check every word it reads against an expected sequence number.

## Interface
- `DEPTH`, 512: FIFO depth in words; also the maximum burst length.
- `WIDTH`, 1024: data word width. Must be a multiple of 32.
- `PTR_WIDTH`, 9: log2(DEPTH).
- `clk1` input 1: write-domain clock. Everything is rising-edge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `start` input 1: one-cycle request to begin a burst. Sampled only in IDLE.
- `burst_len` input PTR_WIDTH+1: number of words in the burst, 0..DEPTH. Captured with `start`.
- `gap_cycles` input 4: idle cycles inserted after each accepted word, 0..15. Captured with `start`.
- `Full` input 1: FIFO full flag from the control unit.
- `Write` output 1: write enable to the control unit. Registered.
- `Data_in` output WIDTH: data word to the FIFO. Registered.
- `Busy` output 1: high while a burst is in progress.
- `Done` output 1: one-cycle pulse when a burst completes.
- `seq` output 32: sequence number of the next word to be written.

## Operation
- **Acceptance rule.** A word is accepted on any `clk1` edge where `Write`=1 and `Full`=0.
- **Word format.** `Data_in` = `{WIDTH/32{seq}}`, i.e. `seq` replicated across the word.
- **Sequence counter.** `seq` increments by 1 per accepted word. It wraps from 0xFFFFFFFF to 0. It persists across bursts and is cleared only by `rst`.
- **State IDLE.**
  - `Write`=0, `Busy`=0.
  - On `start`=1 with `burst_len`>0: capture `burst_len` into `remaining` and `gap_cycles` into `gap`, then go to WRITE.
  - On `start`=1 with `burst_len`=0: pulse `Done` for one cycle, stay in IDLE, no write.
- **State WRITE.**
  - `Write`=1, `Data_in` = pattern(`seq`).
  - While `Full`=1: hold `Write` and `Data_in` unchanged and stay in WRITE.
  - On acceptance: decrement `remaining` and increment `seq`.
    - If `remaining` was 1: go to DONE.
    - Else if `gap`>0: go to GAP with the gap counter = `gap`.
    - Else: stay in WRITE and present the next word on the following cycle.
- **State GAP.** `Write`=0. Decrement the gap counter each cycle; go to WRITE when it reaches 1.
- **State DONE.** `Write`=0, `Done`=1 for exactly one cycle, then IDLE. `Busy` is 0 in this cycle.
- **`Busy`.** Equals 1 in WRITE and GAP.
- **`start` while not in IDLE.** Ignored. It is not queued.
- **Reset.**
  - All outputs go to 0: `Write`, `Data_in`, `Busy`, `Done`, `seq`.
  - State goes to IDLE.
  - `remaining` and the gap counter go to 0.
  - Reset mid-burst abandons the burst. No `Done` is issued.

## Timing
- **`start` to first write:** `start` sampled at edge N gives `Write`=1 from edge N (visible in cycle N+1). First acceptance is possible at edge N+1.
- **Throughput with `gap_cycles`=0 and `Full`=0:** one word per cycle, `Write` continuously high.
- **Period with `gap_cycles`=g:** each word occupies 1+g cycles when `Full`=0.
- **`Full` timing:** `Full` is combinational to the acceptance decision only. `Write` and `Data_in` never change in the same cycle that `Full` is sampled high.
- **`Full` during GAP:** no effect.
- **`Done` timing:** `Done` rises the cycle after the last acceptance.

## Structure
- Shared package `fifo_pkg`, containing:
  - `DEPTH`, `WIDTH`, `PTR_WIDTH`;
  - typedef `prod_state_e` {IDLE, WRITE, GAP, DONE};
  - function `pattern(seq)` returning `{WIDTH/32{seq}}`. The consumer checker reuses this function.
- No sub-module. The FSM and the three counters (`remaining`, gap counter, `seq`) live in one module, about 150–200 lines.

## Test plan
- **Basic burst.** After reset, `start` with `burst_len`=4, `gap_cycles`=0, `Full`=0.
  - `Write` high for 4 consecutive cycles with `seq` 0,1,2,3.
  - `Done` pulses on the next cycle; final `seq`=4.
- **Backpressure.** `burst_len`=3, `gap_cycles`=0, `Full` forced high for 5 cycles after the first acceptance.
  - `Write`=1 and `Data_in`=pattern(1) are held stable for all 5 cycles.
  - Words 1 and 2 are accepted once `Full` drops; `Done` follows.
- **Gap insertion.** `burst_len`=2, `gap_cycles`=3.
  - Acceptances land at cycles 1 and 5 relative to `start`.
  - `Write`=0 for the 3 cycles in between; `Done` at cycle 6.
- **Zero length and ignored start.**
  - `burst_len`=0: `Done` next cycle, `Write` never asserts.
  - A second `start` pulsed mid-burst is ignored: the total number of writes equals the first `burst_len`.
- **Reset mid-burst and resume.** `burst_len`=10, `rst` asserted asynchronously after 3 acceptances.
  - `Write`, `Busy`, `Data_in` and `seq` drop to 0 immediately, and no `Done` is issued.
  - A new burst then starts at `seq`=0.
- **Wrap and full depth.**
  - Preload so that `seq`=0xFFFFFFFE (via prior bursts or force), then run a 4-word burst: `seq` goes FFFFFFFE, FFFFFFFF, 0, 1.
  - A `burst_len`=512 burst produces exactly 512 writes.
